// File: rtl/i2c_nco_regbank.sv
// i2c_nco_regbank: I2C slave register bank that holds per-channel NCO settings
// (enable, waveform select, frequency word, duty-cycle word).
// Optional feature macro: I2C_READBACK_EN lets the master read back the
// register picked by the last command byte with address+R after a repeated START.
`timescale 1ns/1ps
module i2c_nco_regbank #(
    parameter logic [6:0] SLAVE_ADDR = 7'h75,
    parameter int         NUM_CH     = 4,
    parameter int         FREQ_W     = 64,
    parameter int         DUTY_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     scl,
    inout  wire                      sda,
    output logic [NUM_CH-1:0]        nco_enable,
    output logic [2*NUM_CH-1:0]      nco_wave,
    output logic [NUM_CH*FREQ_W-1:0] nco_frequency,
    output logic [NUM_CH*DUTY_W-1:0] nco_duty_cycle,
    output logic                     start,
    output logic                     ack_error
);

    localparam int SH_W   = (FREQ_W > DUTY_W) ? FREQ_W : DUTY_W;
    localparam int FREQ_B = FREQ_W / 8;
    localparam int DUTY_B = DUTY_W / 8;
    localparam int CNT_W  = $clog2(SH_W / 8 + 1);
    localparam logic [DUTY_W-1:0] DUTY_RST = {1'b1, {(DUTY_W-1){1'b0}}};

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, WDATA, WACK, RDATA, RACK
    } state_t;

    // Bus synchronisers and previous-sample registers for edge detection
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_prev_q, sda_prev_q;
    logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    // Protocol state
    state_t           state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             ack_active_q, ack_active_d;
    logic             nack_q, nack_d;
    logic             sda_oe_q, sda_oe_d;
    logic             rw_q, rw_d;
    logic [1:0]       cmd_sel_q, cmd_sel_d;
    logic [5:0]       cmd_ch_q, cmd_ch_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             wr_active_q, wr_active_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [SH_W-1:0]  shadow_q, shadow_d;
    logic             commit_q, commit_d;
    logic             start_q, start_d;
    logic             ack_error_q, ack_error_d;
    logic [7:0]       rx_byte;
    logic [CNT_W-1:0] exp_bytes;
    logic             cmd_ok;

    // Channel register file
    logic [NUM_CH-1:0]             en_q, en_d;
    logic [NUM_CH-1:0][1:0]        wave_q, wave_d;
    logic [NUM_CH-1:0][FREQ_W-1:0] freq_q, freq_d;
    logic [NUM_CH-1:0][DUTY_W-1:0] duty_q, duty_d;

`ifdef I2C_READBACK_EN
    logic [CNT_W-1:0] rd_idx_q, rd_idx_d;
    logic [SH_W-1:0]  rd_word, rd_shifted;
    logic [7:0]       rd_byte;
    logic [2:0]       rd_bit_idx;
    int               rd_shamt;
`endif

    assign sda            = sda_oe_q ? 1'b0 : 1'bz;
    assign nco_enable     = en_q;
    assign nco_wave       = wave_q;
    assign nco_frequency  = freq_q;
    assign nco_duty_cycle = duty_q;
    assign start          = start_q;
    assign ack_error      = ack_error_q;

    // Two-flop synchronisers; idle bus level is high so reset loads ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl};
            sda_sync_q <= {sda_sync_q[0], sda};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    // Payload length implied by the latched register select
    always_comb begin
        exp_bytes = '0;
        case (cmd_sel_q)
            2'b00:   exp_bytes = CNT_W'(1);
            2'b01:   exp_bytes = CNT_W'(FREQ_B);
            2'b10:   exp_bytes = CNT_W'(DUTY_B);
            default: exp_bytes = '0;
        endcase
    end

`ifdef I2C_READBACK_EN
    // Select the addressed register and pick the current read byte, MSB byte first
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (6'(i) == cmd_ch_q) begin
                case (cmd_sel_q)
                    2'b00:   rd_word = SH_W'({wave_q[i], en_q[i]});
                    2'b01:   rd_word = SH_W'(freq_q[i]);
                    2'b10:   rd_word = SH_W'(duty_q[i]);
                    default: rd_word = '0;
                endcase
            end
        end
        rd_shamt   = 8 * (int'(exp_bytes) - 1 - int'(rd_idx_q));
        rd_shifted = rd_word >> rd_shamt;
        rd_byte    = rd_shifted[7:0];
        rd_bit_idx = 3'(4'd7 - bit_cnt_q);
    end
`endif

    // Protocol FSM: START/STOP override everything, otherwise per-state bit handling
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        ack_active_d = ack_active_q;
        nack_d       = nack_q;
        sda_oe_d     = sda_oe_q;
        rw_d         = rw_q;
        cmd_sel_d    = cmd_sel_q;
        cmd_ch_d     = cmd_ch_q;
        cmd_valid_d  = cmd_valid_q;
        wr_active_d  = wr_active_q;
        byte_cnt_d   = byte_cnt_q;
        shadow_d     = shadow_q;
        commit_d     = 1'b0;
        start_d      = 1'b0;
        ack_error_d  = ack_error_q;
        rx_byte      = {shift_q[6:0], sda_s};
        cmd_ok       = (rx_byte[7:6] != 2'b11) && ({1'b0, rx_byte[5:0]} < 7'(NUM_CH));
`ifdef I2C_READBACK_EN
        rd_idx_d     = rd_idx_q;
`endif
        if (start_det) begin
            state_d      = ADDR;
            bit_cnt_d    = '0;
            ack_active_d = 1'b0;
            sda_oe_d     = 1'b0;
            start_d      = 1'b1;
            ack_error_d  = 1'b0;
            commit_d     = wr_active_q && (byte_cnt_q == exp_bytes);
            wr_active_d  = 1'b0;
            byte_cnt_d   = '0;
`ifdef I2C_READBACK_EN
            rd_idx_d     = '0;
`endif
        end else if (stop_det) begin
            state_d      = IDLE;
            ack_active_d = 1'b0;
            sda_oe_d     = 1'b0;
            cmd_valid_d  = 1'b0;
            if (wr_active_q) begin
                if (byte_cnt_q == exp_bytes) commit_d = 1'b1;
                else ack_error_d = 1'b1;
            end
            wr_active_d  = 1'b0;
            byte_cnt_d   = '0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            if (rx_byte[7:1] != SLAVE_ADDR) begin
                                state_d = IDLE;
                            end else begin
                                state_d = ADDR_ACK;
                                rw_d    = rx_byte[0];
`ifdef I2C_READBACK_EN
                                nack_d  = rx_byte[0] & ~cmd_valid_q;
`else
                                nack_d  = rx_byte[0];
`endif
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_active_q) begin
                            ack_active_d = 1'b1;
                            sda_oe_d     = ~nack_q;
                        end else begin
                            ack_active_d = 1'b0;
                            sda_oe_d     = 1'b0;
                            if (nack_q) begin
                                state_d = IDLE;
                            end else if (rw_q) begin
`ifdef I2C_READBACK_EN
                                state_d   = RDATA;
                                bit_cnt_d = '0;
                                sda_oe_d  = ~rd_byte[7];
`else
                                state_d   = IDLE;
`endif
                            end else begin
                                state_d = CMD;
                            end
                        end
                    end
                end
                CMD: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d   = '0;
                            cmd_sel_d   = rx_byte[7:6];
                            cmd_ch_d    = rx_byte[5:0];
                            cmd_valid_d = cmd_ok;
                            nack_d      = ~cmd_ok;
                            state_d     = CMD_ACK;
                        end
                    end
                end
                CMD_ACK, WACK: begin
                    if (scl_fall) begin
                        if (!ack_active_q) begin
                            ack_active_d = 1'b1;
                            sda_oe_d     = ~nack_q;
                        end else begin
                            ack_active_d = 1'b0;
                            sda_oe_d     = 1'b0;
                            bit_cnt_d    = '0;
                            if (state_q == WACK) begin
                                state_d = WDATA;
                            end else if (nack_q) begin
                                state_d = IDLE;
                            end else begin
                                state_d     = WDATA;
                                wr_active_d = 1'b1;
                                byte_cnt_d  = '0;
                                shadow_d    = '0;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            state_d   = WACK;
                            if (byte_cnt_q < exp_bytes) begin
                                shadow_d   = {shadow_q[SH_W-9:0], rx_byte};
                                byte_cnt_d = byte_cnt_q + 1'b1;
                                nack_d     = 1'b0;
                            end else begin
                                nack_d     = 1'b1;
                            end
                        end
                    end
                end
`ifdef I2C_READBACK_EN
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d     = 1'b0;
                            bit_cnt_d    = '0;
                            ack_active_d = 1'b0;
                            state_d      = RACK;
                        end else begin
                            sda_oe_d = ~rd_byte[rd_bit_idx];
                        end
                    end
                end
                RACK: begin
                    if (scl_rise && !ack_active_q) begin
                        if (sda_s) begin
                            state_d = IDLE;
                            if (rd_idx_q != CNT_W'(exp_bytes - 1'b1)) ack_error_d = 1'b1;
                        end else begin
                            ack_active_d = 1'b1;
                            rd_idx_d     = (rd_idx_q == CNT_W'(exp_bytes - 1'b1)) ? '0 : rd_idx_q + 1'b1;
                        end
                    end else if (scl_fall && ack_active_q) begin
                        ack_active_d = 1'b0;
                        bit_cnt_d    = '0;
                        state_d      = RDATA;
                        sda_oe_d     = ~rd_byte[7];
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Atomic commit of the shadow into the selected channel, one clk after STOP/Sr
    always_comb begin
        en_d   = en_q;
        wave_d = wave_q;
        freq_d = freq_q;
        duty_d = duty_q;
        if (commit_q) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (6'(i) == cmd_ch_q) begin
                    case (cmd_sel_q)
                        2'b00: begin
                            en_d[i]   = shadow_q[0];
                            wave_d[i] = shadow_q[2:1];
                        end
                        2'b01:   freq_d[i] = shadow_q[FREQ_W-1:0];
                        2'b10:   duty_d[i] = shadow_q[DUTY_W-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // State and data registers; reset wins over any pending commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            ack_active_q <= 1'b0;
            nack_q       <= 1'b0;
            sda_oe_q     <= 1'b0;
            rw_q         <= 1'b0;
            cmd_sel_q    <= '0;
            cmd_ch_q     <= '0;
            cmd_valid_q  <= 1'b0;
            wr_active_q  <= 1'b0;
            byte_cnt_q   <= '0;
            shadow_q     <= '0;
            commit_q     <= 1'b0;
            start_q      <= 1'b0;
            ack_error_q  <= 1'b0;
            en_q         <= '0;
            wave_q       <= '0;
            freq_q       <= '0;
            duty_q       <= {NUM_CH{DUTY_RST}};
`ifdef I2C_READBACK_EN
            rd_idx_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            ack_active_q <= ack_active_d;
            nack_q       <= nack_d;
            sda_oe_q     <= sda_oe_d;
            rw_q         <= rw_d;
            cmd_sel_q    <= cmd_sel_d;
            cmd_ch_q     <= cmd_ch_d;
            cmd_valid_q  <= cmd_valid_d;
            wr_active_q  <= wr_active_d;
            byte_cnt_q   <= byte_cnt_d;
            shadow_q     <= shadow_d;
            commit_q     <= commit_d;
            start_q      <= start_d;
            ack_error_q  <= ack_error_d;
            en_q         <= en_d;
            wave_q       <= wave_d;
            freq_q       <= freq_d;
            duty_q       <= duty_d;
`ifdef I2C_READBACK_EN
            rd_idx_q     <= rd_idx_d;
`endif
        end
    end

endmodule
